mem_stage_lsu: RTL and testbench

- Memory-access (MEM) stage of the 5-stage MIPS pipeline.
- Upstream: consumes the EX/MEM payload (ALU result/address, store data, op, destination register).
- Downstream: drives the data SRAM port and presents register-write data and address exceptions to WB.
- Generates store byte-enables and replicated store data, and extracts/extends load data.
- Holds SRAM read data when WB back-pressures, because the SRAM output is only valid one cycle after issue.

---
 rtl/mips_pkg.sv | 53 +++++
 rtl/mem_stage_lsu_load_align.sv | 45 ++++
 rtl/mem_stage_lsu.sv | 181 ++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared types and helpers for the MIPS pipeline MEM stage.
//   mem_op_t : memory operation carried in the EX/MEM payload
//   exc_t    : address exception reported to WB
//   dstate_t : state of the MEM-stage output register / load-data FSM
//   isLoad / isStore / isMisaligned : classification helpers
package mips_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LBU  = 4'd2,
      OP_LH   = 4'd3,
      OP_LHU  = 4'd4,
      OP_LW   = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      EXC_NONE = 2'd0,
      EXC_ADEL = 2'd1,
      EXC_ADES = 2'd2
   } exc_t;

   // EMPTY: nothing in the output register.
   // FRESH: first cycle an entry is presented; a load reads the SRAM live.
   // HELD : WB stalled a load, so its word is served from the hold buffer.
   typedef enum logic [1:0] {
      DS_EMPTY = 2'd0,
      DS_FRESH = 2'd1,
      DS_HELD  = 2'd2
   } dstate_t;

   function automatic logic isLoad(input mem_op_t op);
      return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
             (op == OP_LHU) || (op == OP_LW);
   endfunction

   function automatic logic isStore(input mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Halfword accesses need an even address, word accesses a multiple of 4.
   function automatic logic isMisaligned(input mem_op_t op, input logic [1:0] addrLo);
      logic mis;
      mis = 1'b0;
      if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) mis = addrLo[0];
      if ((op == OP_LW) || (op == OP_SW))                   mis = |addrLo;
      return mis;
   endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// load_align: picks the addressed byte/halfword out of a raw SRAM word and
// sign- or zero-extends it to 32 bits according to the load op.
//   op_i     : load op (LB/LBU/LH/LHU/LW; anything else returns raw word)
//   addrLo_i : low two bits of the effective address
//   raw_i    : 32-bit word read from the data SRAM
//   result_o : extended register write-back value
module load_align
   import mips_pkg::*;
(
   input  mem_op_t     op_i,
   input  logic [1:0]  addrLo_i,
   input  logic [31:0] raw_i,
   output logic [31:0] result_o
);

   logic [7:0]  selByte;
   logic [15:0] selHalf;

   // Lane selection: the byte index is addrLo, the half index is addrLo[1]
   // (an aligned halfword never has addrLo[0] set).
   always_comb begin
      selByte = raw_i[7:0];
      case (addrLo_i)
         2'd0: selByte = raw_i[7:0];
         2'd1: selByte = raw_i[15:8];
         2'd2: selByte = raw_i[23:16];
         2'd3: selByte = raw_i[31:24];
         default: selByte = raw_i[7:0];
      endcase
      selHalf = addrLo_i[1] ? raw_i[31:16] : raw_i[15:0];
   end

   // Extension by op; LW and non-loads pass the word through untouched.
   always_comb begin
      result_o = raw_i;
      case (op_i)
         OP_LB:   result_o = {{24{selByte[7]}}, selByte};
         OP_LBU:  result_o = {24'd0, selByte};
         OP_LH:   result_o = {{16{selHalf[15]}}, selHalf};
         OP_LHU:  result_o = {16'd0, selHalf};
         default: result_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage of the 5-stage MIPS pipeline.
//   in_*            : EX/MEM payload with valid/ready handshake
//   flush           : kills the request being accepted and the held entry
//   data_sram_*     : data SRAM port (read data returns one cycle later)
//   out_*           : WB payload with valid/ready handshake, plus
//                     address exception code and faulting address
module mem_stage_lsu
   import mips_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [ADDR_W-1:0] in_addr,
   input  logic [DATA_W-1:0] in_wdata,
   input  logic [ADDR_W-1:0] in_pc,
   input  logic [4:0]        in_wreg,
   input  logic              in_regwen,
   output logic              data_sram_en,
   output logic [3:0]        data_sram_wen,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [DATA_W-1:0] data_sram_wdata,
   input  logic [DATA_W-1:0] data_sram_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_pc,
   output logic              out_regwen,
   output logic [4:0]        out_wreg,
   output logic [DATA_W-1:0] out_wdata,
   output logic [1:0]        out_exc,
   output logic [ADDR_W-1:0] out_badvaddr
);

   mem_op_t           inOp;
   logic              inMis;
   logic              inMem;
   logic              accept;
   logic              issue;

   dstate_t           stateQ, stateD;
   mem_op_t           opQ;
   logic [1:0]        addrLoQ;
   logic [ADDR_W-1:0] pcQ;
   logic [4:0]        wregQ;
   logic              regwenQ;
   logic [DATA_W-1:0] wdataQ;
   exc_t              excQ;
   logic [ADDR_W-1:0] badvaddrQ;
   logic              loadQ;
   logic [DATA_W-1:0] holdBufQ;
   logic [DATA_W-1:0] loadWord;
   logic [DATA_W-1:0] loadExt;

   // Handshake and request classification. Reset also blocks acceptance so
   // nothing reaches the SRAM while the pipeline is being cleared.
   always_comb begin
      inOp      = mem_op_t'(in_op);
      inMis     = isMisaligned(inOp, in_addr[1:0]);
      inMem     = isLoad(inOp) || isStore(inOp);
      out_valid = (stateQ != DS_EMPTY);
      in_ready  = !out_valid || out_ready;
      accept    = in_valid && in_ready && !flush && !reset;
      issue     = accept && inMem && !inMis;
   end

   // SRAM request: only an accepted, aligned memory op drives the port.
   // Narrow stores replicate their data across lanes and let the byte
   // enables select which lanes actually get written.
   always_comb begin
      data_sram_en    = issue;
      data_sram_addr  = reset ? '0 : {in_addr[ADDR_W-1:2], 2'b00};
      data_sram_wen   = 4'b0000;
      data_sram_wdata = '0;
      if (issue) begin
         case (inOp)
            OP_SB: begin
               data_sram_wen   = 4'b0001 << in_addr[1:0];
               data_sram_wdata = {4{in_wdata[7:0]}};
            end
            OP_SH: begin
               data_sram_wen   = in_addr[1] ? 4'b1100 : 4'b0011;
               data_sram_wdata = {2{in_wdata[15:0]}};
            end
            OP_SW: begin
               data_sram_wen   = 4'b1111;
               data_sram_wdata = in_wdata;
            end
            default: begin
               data_sram_wen   = 4'b0000;
               data_sram_wdata = '0;
            end
         endcase
      end
   end

   // Output register: captures the payload on accept. Exception info and
   // the "this entry takes data from the SRAM" flag are resolved here so
   // WB sees a stable, fully decoded entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opQ       <= OP_NONE;
         addrLoQ   <= 2'b00;
         pcQ       <= '0;
         wregQ     <= 5'd0;
         regwenQ   <= 1'b0;
         wdataQ    <= '0;
         excQ      <= EXC_NONE;
         badvaddrQ <= '0;
         loadQ     <= 1'b0;
      end else if (accept) begin
         opQ       <= inOp;
         addrLoQ   <= in_addr[1:0];
         pcQ       <= in_pc;
         wregQ     <= in_wreg;
         regwenQ   <= in_regwen && !inMis;
         wdataQ    <= in_addr;
         excQ      <= !inMis ? EXC_NONE : (isStore(inOp) ? EXC_ADES : EXC_ADEL);
         badvaddrQ <= inMis ? in_addr : '0;
         loadQ     <= isLoad(inOp) && !inMis;
      end
   end

   // Data FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) stateQ <= DS_EMPTY;
      else       stateQ <= stateD;
   end

   // Next state: flush empties the stage from anywhere and beats out_ready.
   // A stalled FRESH entry moves to HELD because the SRAM word disappears
   // after this cycle; HELD stays until WB takes it.
   always_comb begin
      stateD = stateQ;
      if (flush) begin
         stateD = DS_EMPTY;
      end else begin
         case (stateQ)
            DS_EMPTY: stateD = accept ? DS_FRESH : DS_EMPTY;
            DS_FRESH: stateD = !out_ready ? DS_HELD : (accept ? DS_FRESH : DS_EMPTY);
            DS_HELD:  stateD = !out_ready ? DS_HELD : (accept ? DS_FRESH : DS_EMPTY);
            default:  stateD = DS_EMPTY;
         endcase
      end
   end

   // Hold buffer: grabs the one-cycle-valid SRAM word when WB stalls a
   // FRESH entry. Reset discards it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                         holdBufQ <= '0;
      else if (stateQ == DS_FRESH && !out_ready && !flush) holdBufQ <= data_sram_rdata;
   end

   // Load word source: live SRAM data in FRESH, buffered copy in HELD.
   always_comb begin
      loadWord = (stateQ == DS_HELD) ? holdBufQ : data_sram_rdata;
   end

   load_align uLoadAlign (
      .op_i     (opQ),
      .addrLo_i (addrLoQ),
      .raw_i    (loadWord),
      .result_o (loadExt)
   );

   // WB payload: loads return the extracted word, everything else the
   // registered ALU result.
   always_comb begin
      out_pc       = pcQ;
      out_wreg     = wregQ;
      out_regwen   = regwenQ;
      out_exc      = excQ;
      out_badvaddr = badvaddrQ;
      out_wdata    = loadQ ? loadExt : wdataQ;
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: self-checking bench for mem_stage_lsu. Directed
// scenarios followed by a randomized run against a transaction-level model.
module tb_mem_stage_lsu;
   import mips_pkg::*;

   logic        clk, reset, flush;
   logic        in_valid, in_ready, in_regwen;
   logic [3:0]  in_op;
   logic [31:0] in_addr, in_wdata, in_pc;
   logic [4:0]  in_wreg;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
   logic        out_valid, out_ready, out_regwen;
   logic [31:0] out_pc, out_wdata, out_badvaddr;
   logic [4:0]  out_wreg;
   logic [1:0]  out_exc;

   int total = 0;
   int bad   = 0;

   mem_stage_lsu #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_addr(in_addr), .in_wdata(in_wdata), .in_pc(in_pc),
      .in_wreg(in_wreg), .in_regwen(in_regwen),
      .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
      .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
      .data_sram_rdata(data_sram_rdata),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_regwen(out_regwen), .out_wreg(out_wreg), .out_wdata(out_wdata),
      .out_exc(out_exc), .out_badvaddr(out_badvaddr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: value written back for a load of word w at byte offset lo.
   function automatic logic [31:0] refLoad(input logic [3:0] op, input logic [1:0] lo, input logic [31:0] w);
      longint b, h;
      b = longint'((w >> (8 * lo)) & 32'hFF);
      h = longint'((w >> (8 * lo)) & 32'hFFFF);
      case (op)
         4'd1:    return (b >= 128)   ? 32'(b - 256)   : 32'(b);
         4'd2:    return 32'(b);
         4'd3:    return (h >= 32768) ? 32'(h - 65536) : 32'(h);
         4'd4:    return 32'(h);
         default: return w;
      endcase
   endfunction

   function automatic logic refMis(input logic [3:0] op, input logic [1:0] lo);
      int a;
      a = int'(lo);
      if (op == 4'd3 || op == 4'd4 || op == 4'd7) return (a % 2) != 0;
      if (op == 4'd5 || op == 4'd8)               return a != 0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] refWen(input logic [3:0] op, input logic [1:0] lo);
      case (op)
         4'd6:    return 4'(1 << int'(lo));
         4'd7:    return (int'(lo) >= 2) ? 4'hC : 4'h3;
         4'd8:    return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] refWdata(input logic [3:0] op, input logic [31:0] w);
      case (op)
         4'd6:    return (w & 32'hFF) * 32'h0101_0101;
         4'd7:    return (w & 32'hFFFF) * 32'h0001_0001;
         4'd8:    return w;
         default: return 32'h0;
      endcase
   endfunction

   // Drive one cycle's inputs just after the falling edge, then settle.
   task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] pc, input logic [4:0] wreg,
                                input logic rw, input logic rdy, input logic fl, input logic [31:0] rd);
      @(negedge clk);
      in_valid = v; in_op = op; in_addr = addr; in_wdata = wd; in_pc = pc;
      in_wreg = wreg; in_regwen = rw; out_ready = rdy; flush = fl; data_sram_rdata = rd;
      #1;
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      #1;
      total++; if (out_valid !== 1'b0)     begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (out_wdata !== 32'h0)    begin bad++; $display("[TB] FAIL reset_wdata got=%h exp=0", out_wdata); end
      total++; if (out_pc !== 32'h0)       begin bad++; $display("[TB] FAIL reset_pc got=%h exp=0", out_pc); end
      total++; if (data_sram_en !== 1'b0)  begin bad++; $display("[TB] FAIL reset_en got=%b exp=0", data_sram_en); end
      total++; if (out_exc !== 2'd0)       begin bad++; $display("[TB] FAIL reset_exc got=%0d exp=0", out_exc); end
      @(negedge clk); reset = 1'b0;
   endtask

   task automatic test_store_byte;
      applyStimulus(1, OP_SB, 32'h0000_1003, 32'h0000_00AB, 32'h100, 5'd0, 0, 1, 0, 32'h0);
      total++; if (data_sram_en !== 1'b1)            begin bad++; $display("[TB] FAIL sb_en got=%b exp=1", data_sram_en); end
      total++; if (data_sram_wen !== 4'b1000)        begin bad++; $display("[TB] FAIL sb_wen got=%b exp=1000", data_sram_wen); end
      total++; if (data_sram_addr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL sb_addr got=%h exp=00001000", data_sram_addr); end
      total++; if (data_sram_wdata !== 32'hABAB_ABAB) begin bad++; $display("[TB] FAIL sb_wdata got=%h exp=ababab ab", data_sram_wdata); end
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'h0);
      total++; if (out_valid !== 1'b1)  begin bad++; $display("[TB] FAIL sb_valid got=%b exp=1", out_valid); end
      total++; if (out_regwen !== 1'b0) begin bad++; $display("[TB] FAIL sb_regwen got=%b exp=0", out_regwen); end
   endtask

   task automatic test_load_extract;
      logic [3:0]  ops[3]   = '{OP_LH, OP_LHU, OP_LB};
      logic [31:0] addrs[3] = '{32'h0000_2002, 32'h0000_2002, 32'h0000_2001};
      logic [31:0] raws[3]  = '{32'h8001_1234, 32'h8001_1234, 32'h0000_F200};
      logic [31:0] exps[3]  = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FFF2};
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, ops[i], addrs[i], 0, 32'h200 + i, 5'd3, 1, 1, 0, 32'h0);
         total++; if (data_sram_en !== 1'b1 || data_sram_wen !== 4'b0) begin bad++; $display("[TB] FAIL ld%0d_issue got en=%b wen=%b exp en=1 wen=0", i, data_sram_en, data_sram_wen); end
         applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, raws[i]);
         total++; if (out_wdata !== exps[i]) begin bad++; $display("[TB] FAIL ld%0d_data got=%h exp=%h", i, out_wdata, exps[i]); end
         total++; if (out_regwen !== 1'b1 || out_wreg !== 5'd3) begin bad++; $display("[TB] FAIL ld%0d_reg got=%b/%0d exp=1/3", i, out_regwen, out_wreg); end
      end
   endtask

   task automatic test_misaligned;
      applyStimulus(1, OP_LW, 32'h0000_3001, 0, 32'h300, 5'd4, 1, 1, 0, 32'h0);
      total++; if (data_sram_en !== 1'b0) begin bad++; $display("[TB] FAIL adel_en got=%b exp=0", data_sram_en); end
      applyStimulus(1, OP_SH, 32'h0000_0005, 32'h1234, 32'h304, 5'd0, 0, 1, 0, 32'h0);
      total++; if (out_exc !== 2'd1)                begin bad++; $display("[TB] FAIL adel_exc got=%0d exp=1", out_exc); end
      total++; if (out_badvaddr !== 32'h0000_3001)  begin bad++; $display("[TB] FAIL adel_bad got=%h exp=00003001", out_badvaddr); end
      total++; if (out_regwen !== 1'b0)             begin bad++; $display("[TB] FAIL adel_regwen got=%b exp=0", out_regwen); end
      total++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0) begin bad++; $display("[TB] FAIL ades_sram got en=%b wen=%b exp 0/0", data_sram_en, data_sram_wen); end
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'h0);
      total++; if (out_exc !== 2'd2 || out_badvaddr !== 32'h5) begin bad++; $display("[TB] FAIL ades_exc got=%0d/%h exp=2/00000005", out_exc, out_badvaddr); end
   endtask

   task automatic test_backpressure;
      applyStimulus(1, OP_LW, 32'h0000_4000, 0, 32'h400, 5'd5, 1, 1, 0, 32'h0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1, OP_SW, 32'h0000_4100, 32'h99, 32'h404, 5'd0, 0, 0, 0, (c == 0) ? 32'h1111_1111 : 32'hDEAD_BEEF);
         total++; if (out_valid !== 1'b1 || out_wdata !== 32'h1111_1111) begin bad++; $display("[TB] FAIL stall%0d_data got=%b/%h exp=1/11111111", c, out_valid, out_wdata); end
         total++; if (in_ready !== 1'b0 || data_sram_en !== 1'b0) begin bad++; $display("[TB] FAIL stall%0d_ready got rdy=%b en=%b exp 0/0", c, in_ready, data_sram_en); end
      end
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF);
      total++; if (out_valid !== 1'b1 || out_wdata !== 32'h1111_1111) begin bad++; $display("[TB] FAIL release_data got=%b/%h exp=1/11111111", out_valid, out_wdata); end
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'h0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL release_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back;
      applyStimulus(1, OP_NONE, 32'h0000_1234, 0, 32'h500, 5'd6, 1, 1, 0, 32'h0);
      applyStimulus(1, OP_LW, 32'h0000_0100, 0, 32'h504, 5'd7, 1, 1, 0, 32'h0);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_wdata !== 32'h1234 || out_pc !== 32'h500) begin bad++; $display("[TB] FAIL b2b_none got rdy=%b v=%b d=%h pc=%h exp 1/1/00001234/00000500", in_ready, out_valid, out_wdata, out_pc); end
      applyStimulus(1, OP_SW, 32'h0000_0200, 32'h0BAD_F00D, 32'h508, 5'd0, 0, 1, 0, 32'hCAFE_F00D);
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_wdata !== 32'hCAFE_F00D || out_pc !== 32'h504) begin bad++; $display("[TB] FAIL b2b_lw got rdy=%b v=%b d=%h pc=%h exp 1/1/cafef00d/00000504", in_ready, out_valid, out_wdata, out_pc); end
      total++; if (data_sram_wen !== 4'hF || data_sram_wdata !== 32'h0BAD_F00D) begin bad++; $display("[TB] FAIL b2b_sw_port got wen=%h wd=%h exp f/0badf00d", data_sram_wen, data_sram_wdata); end
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'h0);
      total++; if (out_valid !== 1'b1 || out_pc !== 32'h508 || out_regwen !== 1'b0) begin bad++; $display("[TB] FAIL b2b_sw got v=%b pc=%h rw=%b exp 1/00000508/0", out_valid, out_pc, out_regwen); end
   endtask

   task automatic test_flush;
      applyStimulus(1, OP_LW, 32'h0000_0500, 0, 32'h600, 5'd8, 1, 1, 0, 32'h0);
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 0, 0, 32'h55AA_55AA);
      applyStimulus(1, OP_SW, 32'h0000_0600, 32'h77, 32'h604, 5'd0, 0, 1, 1, 32'h0);
      total++; if (data_sram_en !== 1'b0 || data_sram_wen !== 4'b0) begin bad++; $display("[TB] FAIL flush_sram got en=%b wen=%b exp 0/0", data_sram_en, data_sram_wen); end
      total++; if (out_valid !== 1'b1 || out_wdata !== 32'h55AA_55AA) begin bad++; $display("[TB] FAIL flush_held got=%b/%h exp=1/55aa55aa", out_valid, out_wdata); end
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'h0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL flush_empty got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid;
      applyStimulus(1, OP_LW, 32'h0000_0040, 0, 32'h700, 5'd9, 1, 1, 0, 32'h0);
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
      total++; if (out_valid !== 1'b1 || out_wdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL rmid_fresh got=%b/%h exp=1/12345678", out_valid, out_wdata); end
      reset = 1'b1; #1;
      total++; if (out_valid !== 1'b0 || out_wdata !== 32'h0 || out_pc !== 32'h0 || out_regwen !== 1'b0 || data_sram_en !== 1'b0) begin bad++; $display("[TB] FAIL rmid_clear got v=%b d=%h pc=%h rw=%b en=%b exp all 0", out_valid, out_wdata, out_pc, out_regwen, data_sram_en); end
      @(negedge clk); reset = 1'b0;
   endtask

   // Randomized run against a transaction model: one output slot, which
   // for a load remembers the SRAM word seen on its first presented cycle.
   task automatic test_random;
      logic        mValid = 0, mFirst = 0;
      logic [3:0]  mOp = 0;
      logic [1:0]  mLo = 0;
      logic [31:0] mPc = 0, mAddr = 0, mBad = 0, mWord = 0;
      logic [4:0]  mWreg = 0;
      logic        mRw = 0;
      logic [1:0]  mExc = 0;
      for (int n = 0; n < 600; n++) begin
         logic v, rw, rdy, fl, acc, mis, expEn, expRdy;
         logic [3:0]  op;
         logic [31:0] addr, wd, pc, rd, expD;
         logic [4:0]  wreg;
         v = ($urandom % 4) != 0; op = 4'($urandom_range(0, 8)); addr = $urandom; wd = $urandom;
         pc = $urandom; wreg = 5'($urandom); rw = 1'($urandom); rdy = ($urandom % 3) != 0;
         fl = ($urandom % 16) == 0; rd = $urandom;
         applyStimulus(v, op, addr, wd, pc, wreg, rw, rdy, fl, rd);
         expRdy = !mValid || rdy;
         acc    = v && expRdy && !fl;
         mis    = refMis(op, addr[1:0]);
         expEn  = acc && (op != 4'd0) && !mis;
         total++; if (in_ready !== expRdy) begin bad++; $display("[TB] FAIL rnd%0d_ready got=%b exp=%b", n, in_ready, expRdy); end
         total++; if (data_sram_en !== expEn) begin bad++; $display("[TB] FAIL rnd%0d_en got=%b exp=%b", n, data_sram_en, expEn); end
         total++; if (data_sram_wen !== (expEn ? refWen(op, addr[1:0]) : 4'h0)) begin bad++; $display("[TB] FAIL rnd%0d_wen got=%b op=%0d", n, data_sram_wen, op); end
         total++; if (data_sram_wdata !== (expEn ? refWdata(op, wd) : 32'h0)) begin bad++; $display("[TB] FAIL rnd%0d_wdata got=%h exp=%h", n, data_sram_wdata, expEn ? refWdata(op, wd) : 32'h0); end
         total++; if (data_sram_addr !== (addr & 32'hFFFF_FFFC)) begin bad++; $display("[TB] FAIL rnd%0d_addr got=%h exp=%h", n, data_sram_addr, addr & 32'hFFFF_FFFC); end
         total++; if (out_valid !== mValid) begin bad++; $display("[TB] FAIL rnd%0d_valid got=%b exp=%b", n, out_valid, mValid); end
         if (mValid) begin
            total++; if (out_pc !== mPc || out_wreg !== mWreg || out_regwen !== mRw) begin bad++; $display("[TB] FAIL rnd%0d_fields got=%h/%0d/%b exp=%h/%0d/%b", n, out_pc, out_wreg, out_regwen, mPc, mWreg, mRw); end
            total++; if (out_exc !== mExc || out_badvaddr !== mBad) begin bad++; $display("[TB] FAIL rnd%0d_exc got=%0d/%h exp=%0d/%h", n, out_exc, out_badvaddr, mExc, mBad); end
            if (mOp == 4'd0 || (mOp <= 4'd5 && mExc == 2'd0)) begin
               expD = (mOp == 4'd0) ? mAddr : refLoad(mOp, mLo, mFirst ? rd : mWord);
               total++; if (out_wdata !== expD) begin bad++; $display("[TB] FAIL rnd%0d_wdata got=%h exp=%h", n, out_wdata, expD); end
            end
         end
         if (fl) begin
            mValid = 0;
         end else if (mValid && !rdy) begin
            if (mFirst) mWord = rd;
            mFirst = 0;
         end else if (acc) begin
            mValid = 1; mFirst = 1; mOp = op; mLo = addr[1:0]; mPc = pc; mAddr = addr;
            mWreg = wreg; mRw = rw && !mis;
            mExc = !mis ? 2'd0 : ((op >= 4'd6) ? 2'd2 : 2'd1);
            mBad = mis ? addr : 32'h0;
         end else begin
            mValid = 0;
         end
      end
      applyStimulus(0, OP_NONE, 0, 0, 0, 0, 0, 1, 0, 32'h0);
   endtask

   // Scenario sequence: reset first, directed features, then random traffic.
   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 4'd0; in_addr = 32'h0;
      in_wdata = 32'h0; in_pc = 32'h0; in_wreg = 5'd0; in_regwen = 1'b0;
      out_ready = 1'b1; data_sram_rdata = 32'h0;
      test_reset;
      test_store_byte;
      test_load_extract;
      test_misaligned;
      test_backpressure;
      test_back_to_back;
      test_flush;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
